// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and legality rule for the banked data memory
// Used by dmem_banked_hs and dmem_lane_align; DMEM_CLEAR_EN selects the CLEAR reset state in the top.
package dmem_pkg;

  localparam int LANES = 4;

  typedef enum logic [2:0] {
    OP_B  = 3'b000,
    OP_H  = 3'b001,
    OP_W  = 3'b010,
    OP_BU = 3'b100,
    OP_HU = 3'b101
  } dmem_op_e;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    RESP  = 2'd2
  } dmem_state_e;

  // Range checking is done by the caller; this only covers op/alignment/direction.
  function automatic logic is_legal(input logic [2:0] op, input logic we, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (dmem_op_e'(op))
      OP_B:    ok = 1'b1;
      OP_H:    ok = ~addr_lo[0];
      OP_W:    ok = (addr_lo == 2'b00);
      OP_BU:   ok = ~we;
      OP_HU:   ok = ~we & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering for stores and lane select/extension for loads
// Purely combinational; legality gating is applied by the caller.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wlanes,
  output logic [31:0] rdata
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    be     = 4'b0000;
    wlanes = wdata;
    rdata  = 32'h0;
    rbyte  = 8'(rword >> {addr_lo, 3'b000});
    rhalf  = addr_lo[1] ? rword[31:16] : rword[15:0];
    case (dmem_op_e'(op))
      OP_B: begin
        be     = 4'b0001 << addr_lo;
        wlanes = {4{wdata[7:0]}};
        rdata  = {{24{rbyte[7]}}, rbyte};
      end
      OP_BU: begin
        be     = 4'b0001 << addr_lo;
        wlanes = {4{wdata[7:0]}};
        rdata  = {24'h0, rbyte};
      end
      OP_H: begin
        be     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{wdata[15:0]}};
        rdata  = {{16{rhalf[15]}}, rhalf};
      end
      OP_HU: begin
        be     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{wdata[15:0]}};
        rdata  = {16'h0, rhalf};
      end
      OP_W: begin
        be     = 4'b1111;
        rdata  = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_banked_hs.sv
// rtl/dmem_banked_hs.sv - banked byte-addressable data memory with valid/ready request/response
// Optional DMEM_CLEAR_EN: zero the whole array one word per cycle after reset before accepting traffic.
module dmem_banked_hs
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int WORDS = DEPTH_BYTES / LANES;
  localparam int IDX_W = $clog2(WORDS);

`ifdef DMEM_CLEAR_EN
  localparam dmem_state_e RST_STATE = CLEAR;
`else
  localparam dmem_state_e RST_STATE = IDLE;
`endif

  dmem_state_e      state_q, state_d;
  logic             init_q;
  logic [31:0]      rdata_q;
  logic             err_q;
  logic [IDX_W-1:0] word_idx;
  logic             in_range, legal, accept, wr_en;
  logic [3:0]       be;
  logic [31:0]      wlanes, rword, ld_data;
  logic             clear_last;
  logic             clearing;

  assign word_idx = req_addr[IDX_W+1:2];
  assign in_range = (req_addr < ADDR_W'(DEPTH_BYTES));
  assign legal    = in_range & is_legal(req_op, req_we, req_addr[1:0]);
  assign accept   = req_valid & req_ready;
  assign wr_en    = accept & req_we & legal;
  assign clearing = (state_q == CLEAR);

`ifdef DMEM_CLEAR_EN
  logic [IDX_W-1:0] clr_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_idx <= '0;
    end else if (clearing) begin
      clr_idx <= clr_idx + IDX_W'(1);
    end
  end

  assign clear_last = (clr_idx == IDX_W'(WORDS - 1));
`else
  assign clear_last = 1'b1;
`endif

  dmem_lane_align u_align (
    .op      (req_op),
    .addr_lo (req_addr[1:0]),
    .wdata   (req_wdata),
    .rword   (rword),
    .be      (be),
    .wlanes  (wlanes),
    .rdata   (ld_data)
  );

  // One byte array per lane keeps each lane a plain single-write-port RAM.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] mem [0:WORDS-1];

    always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_EN
      if (clearing) begin
        mem[clr_idx] <= 8'h00;
      end else
`endif
      if (wr_en && be[l]) begin
        mem[word_idx] <= wlanes[8*l +: 8];
      end
    end

    assign rword[8*l +: 8] = mem[word_idx];
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    case (state_q)
      CLEAR: begin
        if (clear_last) state_d = IDLE;
      end
      IDLE: begin
        req_ready = init_q;
        if (req_valid && init_q) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          req_ready = 1'b1;
          if (!req_valid) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      init_q  <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= (state_d != CLEAR);
      if (accept) begin
        err_q   <= ~legal;
        rdata_q <= (legal && !req_we) ? ld_data : 32'h0;
      end else if (rsp_valid && rsp_ready) begin
        err_q   <= 1'b0;
        rdata_q <= 32'h0;
      end
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign init_done = init_q;

endmodule

// File: tb/tb_dmem_banked_hs.sv
// tb/tb_dmem_banked_hs.sv - directed bench with a byte-array reference model and per-cycle response checking
// Build with or without DMEM_CLEAR_EN; the reset/clear scenario adapts to the macro.
module tb_dmem_banked_hs;

  localparam int DEPTH = 1024;
  localparam int WORDS = DEPTH / 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  always #5 clk = ~clk;

  dmem_banked_hs #(.DEPTH_BYTES(DEPTH), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_done (init_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic [7:0]  mm [0:DEPTH-1];
  rsp_t        exp_q[$];
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: byte-addressed little-endian memory, rules applied directly to addresses.
  function automatic rsp_t model(input logic we, input logic [2:0] op, input logic [31:0] addr,
                                 input logic [31:0] wd);
    rsp_t r;
    logic bad;
    int   a;
    bad = (addr >= 32'(DEPTH)) || (op == 3'd3) || (op == 3'd6) || (op == 3'd7) ||
          (we && (op == 3'd4 || op == 3'd5)) ||
          ((op == 3'd1 || op == 3'd5) && addr[0]) ||
          (op == 3'd2 && addr[1:0] != 2'b00);
    r.err   = bad;
    r.rdata = 32'h0;
    a = int'(addr[9:0]);
    if (!bad) begin
      if (we) begin
        mm[a] = wd[7:0];
        if (op == 3'd1 || op == 3'd2) mm[a+1] = wd[15:8];
        if (op == 3'd2) begin
          mm[a+2] = wd[23:16];
          mm[a+3] = wd[31:24];
        end
      end else begin
        case (op)
          3'd0:    r.rdata = {{24{mm[a][7]}}, mm[a]};
          3'd4:    r.rdata = {24'h0, mm[a]};
          3'd1:    r.rdata = {{16{mm[a+1][7]}}, mm[a+1], mm[a]};
          3'd5:    r.rdata = {16'h0, mm[a+1], mm[a]};
          default: r.rdata = {mm[a+3], mm[a+2], mm[a+1], mm[a]};
        endcase
      end
    end
    return r;
  endfunction

  always @(negedge rst_n) begin
    exp_q.delete();
`ifdef DMEM_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) mm[i] = 8'h00;
`endif
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 rdata %h expected no response", rsp_rdata);
        end else begin
          chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
          chk("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
          if (rsp_ready) begin
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
            void'(exp_q.pop_front());
          end
        end
      end
      if (req_valid && req_ready) exp_q.push_back(model(req_we, req_op, req_addr, req_wdata));
    end
  end

  task automatic drive(input logic we, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    req_we    = we;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 2000) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) chk({name, "_timeout"}, 32'(req_ready), 32'd1);
  endtask

  task automatic req(input logic we, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    drive(we, op, addr, wd);
    wait_ready("req");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(output int cycles);
    cycles = 0;
    while (!init_done && cycles < 2000) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  initial begin
    int n;
    #12;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_init_done", 32'(init_done), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

`ifdef DMEM_CLEAR_EN
    wait_init(n);
    chk("clear_cycles", 32'(n), 32'(WORDS));
    repeat (40) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midsweep_init_low", 32'(init_done), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_init(n);
    chk("clear_restart_cycles", 32'(n), 32'(WORDS));
    req(1'b0, 3'd2, 32'h3FC, 32'h0);
    chk("clear_lw_3fc", last_rdata, 32'h0);
`else
    chk("init_before_edge", 32'(init_done), 32'd0);
    @(posedge clk);
    #1;
    chk("init_one_cycle", 32'(init_done), 32'd1);
`endif

    req(1'b1, 3'd2, 32'h10, 32'h8000_00FF);
    req(1'b0, 3'd0, 32'h10, 32'h0);
    chk("t1_lb", last_rdata, 32'hFFFF_FFFF);
    req(1'b0, 3'd4, 32'h13, 32'h0);
    chk("t1_lbu", last_rdata, 32'h0000_0080);
    req(1'b0, 3'd2, 32'h10, 32'h0);
    chk("t1_lw", last_rdata, 32'h8000_00FF);

    req(1'b1, 3'd2, 32'h20, 32'h1111_2222);
    req(1'b1, 3'd1, 32'h22, 32'h0000_ABCD);
    req(1'b0, 3'd1, 32'h22, 32'h0);
    chk("t2_lh", last_rdata, 32'hFFFF_ABCD);
    req(1'b0, 3'd5, 32'h22, 32'h0);
    chk("t2_lhu", last_rdata, 32'h0000_ABCD);
    req(1'b0, 3'd2, 32'h20, 32'h0);
    chk("t2_lw_upper", {16'h0, last_rdata[31:16]}, 32'h0000_ABCD);

    req(1'b1, 3'd2, 32'h00, 32'hCAFE_F00D);
    req(1'b0, 3'd2, 32'h02, 32'h0);
    chk("t3_lw_mis_err", 32'(last_err), 32'd1);
    chk("t3_lw_mis_data", last_rdata, 32'h0);
    req(1'b1, 3'd1, 32'h01, 32'h0000_5555);
    chk("t3_sh_mis_err", 32'(last_err), 32'd1);
    req(1'b0, 3'd2, 32'(DEPTH), 32'h0);
    chk("t3_range_err", 32'(last_err), 32'd1);
    req(1'b0, 3'd3, 32'h00, 32'h0);
    chk("t3_op011_err", 32'(last_err), 32'd1);
    req(1'b1, 3'd4, 32'h00, 32'h0000_0077);
    chk("t3_sbu_err", 32'(last_err), 32'd1);
    req(1'b0, 3'd2, 32'h00, 32'h0);
    chk("t3_unchanged", last_rdata, 32'hCAFE_F00D);

    @(posedge clk);
    #1;
    req_valid = 1'b1;
    drive(1'b1, 3'd2, 32'h40, 32'h1234_5678);
    wait_ready("t4_sw");
    @(posedge clk);
    #1;
    drive(1'b0, 3'd2, 32'h40, 32'h0);
    @(negedge clk);
    chk("t4_b2b_ready", 32'(req_ready), 32'd1);
    chk("t4_b2b_rsp_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("t4_b2b_lw", last_rdata, 32'h1234_5678);

    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    drive(1'b0, 3'd2, 32'h40, 32'h0);
    wait_ready("t4_stall_lw");
    @(posedge clk);
    #1;
    drive(1'b0, 3'd4, 32'h43, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_stall_valid", 32'(rsp_valid), 32'd1);
      chk("t4_stall_ready", 32'(req_ready), 32'd0);
      chk("t4_stall_data", rsp_rdata, 32'h1234_5678);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("t4_after_stall_lbu", last_rdata, 32'h0000_0012);

    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    drive(1'b0, 3'd2, 32'h40, 32'h0);
    wait_ready("t6_lw");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("t6_rsp_pending", 32'(rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_drop", 32'(rsp_valid), 32'd0);
    chk("t6_async_rdata", rsp_rdata, 32'h0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_init(n);
    chk("t6_init_back", 32'(init_done), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_no_stale", 32'(rsp_valid), 32'd0);
    end
    req(1'b0, 3'd2, 32'h40, 32'h0);

    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

endmodule
